// File: rtl/memory_game_ctrl_pkg.sv
// Shared definitions for the LED memory game sequencer:
// state codes, level one-hots, level length and LFSR constants.
package memory_game_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_GEN   = 3'd1,
        S_SHOW  = 3'd2,
        S_INPUT = 3'd3,
        S_PASS  = 3'd4,
        S_FAIL  = 3'd5,
        S_WIN   = 3'd6
    } state_t;

    localparam logic [2:0] LVL_8  = 3'b001;
    localparam logic [2:0] LVL_12 = 3'b010;
    localparam logic [2:0] LVL_16 = 3'b100;

    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    function automatic logic [4:0] level_len(input logic [2:0] lvl);
        logic [4:0] len;
        case (lvl)
            LVL_12:  len = 5'd12;
            LVL_16:  len = 5'd16;
            default: len = 5'd8;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/memory_game_ctrl_lfsr16.sv
// Free-running 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1).
// A zero seed would lock up, so it is replaced by the default seed.
module game_lfsr16
    import memory_game_ctrl_pkg::*;
#(
    parameter logic [15:0] SEED = DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] lfsr
);

    localparam logic [15:0] INIT = (SEED == 16'h0) ? DEFAULT_SEED : SEED;

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr <= INIT;
        end else begin
            lfsr <= (lfsr >> 1) ^ (lfsr[0] ? LFSR_TAPS : 16'h0);
        end
    end

endmodule

// File: rtl/memory_game_ctrl.sv
// LED memory game sequencer: pattern generation, display handshake and press checking.
// Optional per-press input timeout is compiled in with INPUT_TIMEOUT_EN.
module memory_game_ctrl
    import memory_game_ctrl_pkg::*;
#(
    parameter logic [15:0] SEED           = DEFAULT_SEED,
    parameter int          TIMEOUT_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  btn,
    input  logic        print_pattern_end,
    output logic        print_rst_n,
    output logic        print_en,
    output logic [2:0]  level,
    output logic [47:0] pattern_flat,
    output logic [2:0]  state,
    output logic [3:0]  progress,
    output logic        fail,
    output logic        win
);

    logic [15:0] lfsr;
    logic        unused_lfsr;

    game_lfsr16 #(.SEED(SEED)) u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .lfsr (lfsr)
    );

    assign unused_lfsr = ^lfsr[15:3];

    state_t     st_q, st_n;
    logic [2:0] level_n;
    logic [3:0] prog_n;
    logic [3:0] gen_idx;
    logic [7:0] btn_s, btn_p, rise;
    logic       rise_one;
    logic [2:0] rise_idx;
    logic [2:0] want;

    assign state = st_q;

    always_comb begin
        rise     = btn_s & ~btn_p;
        rise_one = $onehot(rise);
        rise_idx = 3'd0;
        for (int k = 0; k < 8; k++) begin
            if (rise[k]) rise_idx = 3'(k);
        end
        want = pattern_flat[3*progress +: 3];
    end

`ifdef INPUT_TIMEOUT_EN
    logic [31:0] tcnt;
    logic        accept;

    assign accept = (st_q == S_INPUT) && rise_one && (rise_idx == want);

    always_ff @(posedge clk) begin
        if (rst) begin
            tcnt <= '0;
        end else if (st_q != S_INPUT || accept) begin
            tcnt <= '0;
        end else begin
            tcnt <= tcnt + 32'd1;
        end
    end
`endif

    always_comb begin
        st_n    = st_q;
        level_n = level;
        prog_n  = progress;
        case (st_q)
            S_IDLE: begin
                if (start) begin
                    st_n    = S_GEN;
                    level_n = LVL_8;
                    prog_n  = 4'd0;
                end
            end
            S_GEN: begin
                if (gen_idx == 4'd15) st_n = S_SHOW;
            end
            S_SHOW: begin
                if (print_pattern_end) begin
                    st_n   = S_INPUT;
                    prog_n = 4'd0;
                end
            end
            S_INPUT: begin
                // a press in the timeout cycle takes priority over the timeout
                if (rise != 8'd0) begin
                    if (rise_one && rise_idx == want) begin
                        prog_n = progress + 4'd1;
                        if ({1'b0, progress} + 5'd1 == level_len(level))
                            st_n = S_PASS;
                    end else begin
                        st_n = S_FAIL;
                    end
                end
`ifdef INPUT_TIMEOUT_EN
                else if (tcnt == 32'(TIMEOUT_CYCLES - 1)) begin
                    st_n = S_FAIL;
                end
`endif
            end
            S_PASS: begin
                if (level == LVL_16) begin
                    st_n = S_WIN;
                end else begin
                    st_n    = S_GEN;
                    level_n = level << 1;
                end
            end
            S_FAIL, S_WIN: begin
                if (start) begin
                    st_n    = S_GEN;
                    level_n = LVL_8;
                    prog_n  = 4'd0;
                end
            end
            default: st_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q         <= S_IDLE;
            level        <= LVL_8;
            progress     <= 4'd0;
            gen_idx      <= 4'd0;
            pattern_flat <= '0;
            btn_s        <= 8'd0;
            btn_p        <= 8'd0;
            print_rst_n  <= 1'b0;
            print_en     <= 1'b0;
            fail         <= 1'b0;
            win          <= 1'b0;
        end else begin
            st_q        <= st_n;
            level       <= level_n;
            progress    <= prog_n;
            btn_s       <= btn;
            btn_p       <= btn_s;
            gen_idx     <= (st_q == S_GEN) ? gen_idx + 4'd1 : 4'd0;
            print_rst_n <= (st_n == S_SHOW);
            print_en    <= (st_n == S_SHOW);
            fail        <= (st_n == S_FAIL);
            win         <= (st_n == S_WIN);
            if (st_q == S_GEN) pattern_flat[3*gen_idx +: 3] <= lfsr[2:0];
        end
    end

endmodule

// File: tb/tb_memory_game_ctrl.sv
// Self-checking bench for memory_game_ctrl against a cycle-indexed LFSR history model.
// Timeout scenario runs only when INPUT_TIMEOUT_EN is defined.
module tb_memory_game_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  btn = 8'd0;
    logic        ppe = 1'b0;
    logic        print_rst_n, print_en, fail, win;
    logic [2:0]  level, state;
    logic [47:0] pattern_flat;
    logic [3:0]  progress;

    int n_cmp = 0;
    int n_err = 0;

    memory_game_ctrl #(.SEED(16'hACE1), .TIMEOUT_CYCLES(100)) dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .btn               (btn),
        .print_pattern_end (ppe),
        .print_rst_n       (print_rst_n),
        .print_en          (print_en),
        .level             (level),
        .pattern_flat      (pattern_flat),
        .state             (state),
        .progress          (progress),
        .fail              (fail),
        .win               (win)
    );

    always #5 clk = ~clk;

    // LFSR value during every cycle, indexed by number of edges seen
    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        int x;
        x = int'(v) / 2;
        if (v % 2 == 1) x = x ^ 'hB400;
        return 16'(x);
    endfunction

    int          cyc = 0;
    logic [15:0] lfm;
    logic [15:0] ring [256];

    always @(posedge clk) begin
        lfm <= rst ? 16'hACE1 : lfsr_next(lfm);
        ring[(cyc + 1) & 255] <= rst ? 16'hACE1 : lfsr_next(lfm);
        cyc <= cyc + 1;
    end

    logic [2:0] pat [16];

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
        n_cmp++;
        if (state !== 3'd1) begin
            n_err++;
            $display("FAIL start_to_gen: state %0d want 1", state);
        end
    endtask

    task automatic gen_show(input logic [2:0] exp_lvl);
        int c;
        logic [47:0] exp_pat;
        c = cyc;
        n_cmp++;
        if (level !== exp_lvl) begin
            n_err++;
            $display("FAIL gen_level: %b want %b", level, exp_lvl);
        end
        step(16);
        for (int g = 0; g < 16; g++) begin
            pat[g] = ring[(c + g) & 255][2:0];
            exp_pat[3*g +: 3] = pat[g];
        end
        n_cmp++;
        if (state !== 3'd2 || print_rst_n !== 1'b1 || print_en !== 1'b1) begin
            n_err++;
            $display("FAIL show_entry: state %0d rst_n %b en %b want 2 1 1",
                     state, print_rst_n, print_en);
        end
        n_cmp++;
        if (pattern_flat !== exp_pat) begin
            n_err++;
            $display("FAIL pattern: %h want %h", pattern_flat, exp_pat);
        end
    endtask

    task automatic show_to_input(input int wait_cyc);
        step(wait_cyc);
        n_cmp++;
        if (state !== 3'd2) begin
            n_err++;
            $display("FAIL show_hold: state %0d want 2", state);
        end
        ppe = 1'b1;
        step(1);
        ppe = 1'b0;
        n_cmp++;
        if (state !== 3'd3 || progress !== 4'd0 || print_rst_n !== 1'b0 || print_en !== 1'b0) begin
            n_err++;
            $display("FAIL input_entry: state %0d prog %0d rst_n %b en %b want 3 0 0 0",
                     state, progress, print_rst_n, print_en);
        end
    endtask

    task automatic press_ok(input int idx, input int cnt, input bit last);
        btn = 8'(1 << idx);
        step(2);
        n_cmp++;
        if (progress !== 4'(cnt) || state !== (last ? 3'd4 : 3'd3)) begin
            n_err++;
            $display("FAIL press_%0d: prog %0d state %0d want %0d %0d",
                     cnt, progress, state, cnt % 16, last ? 4 : 3);
        end
        btn = 8'd0;
        if (!last) step(2);
    endtask

    task automatic play_round(input int len, input logic [2:0] after_state);
        for (int i = 0; i < len; i++) press_ok(pat[i], i + 1, i == len - 1);
        step(1);
        n_cmp++;
        if (state !== after_state) begin
            n_err++;
            $display("FAIL pass_exit: state %0d want %0d", state, after_state);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(3);
        rst = 1'b0;
        step(20);
        n_cmp++;
        if (state !== 3'd0 || level !== 3'b001) begin
            n_err++;
            $display("FAIL reset_state: state %0d level %b want 0 001", state, level);
        end
        n_cmp++;
        if (print_rst_n !== 1'b0 || print_en !== 1'b0) begin
            n_err++;
            $display("FAIL reset_print: rst_n %b en %b want 0 0", print_rst_n, print_en);
        end
        n_cmp++;
        if (fail !== 1'b0 || win !== 1'b0 || progress !== 4'd0) begin
            n_err++;
            $display("FAIL reset_flags: fail %b win %b prog %0d want 0 0 0", fail, win, progress);
        end
        n_cmp++;
        if (pattern_flat !== 48'd0) begin
            n_err++;
            $display("FAIL reset_pattern: %h want 0", pattern_flat);
        end
    endtask

    task automatic test_round_pass();
        step($urandom_range(0, 40));
        pulse_start();
        gen_show(3'b001);
        show_to_input(30);
        play_round(8, 3'd1);
        gen_show(3'b010);
    endtask

    task automatic test_reset_in_show();
        step($urandom_range(1, 10));
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        n_cmp++;
        if (state !== 3'd0 || print_rst_n !== 1'b0 || level !== 3'b001) begin
            n_err++;
            $display("FAIL rst_in_show: state %0d rst_n %b level %b want 0 0 001",
                     state, print_rst_n, level);
        end
    endtask

    task automatic test_wrong_press();
        int wrong;
        step($urandom_range(0, 40));
        pulse_start();
        gen_show(3'b001);
        show_to_input($urandom_range(1, 40));
        for (int i = 0; i < 3; i++) press_ok(pat[i], i + 1, 1'b0);
        wrong = (pat[3] + 1 + $urandom_range(0, 6)) % 8;
        btn = 8'(1 << wrong);
        step(2);
        btn = 8'd0;
        n_cmp++;
        if (state !== 3'd5 || fail !== 1'b1 || progress !== 4'd3) begin
            n_err++;
            $display("FAIL wrong_press: state %0d fail %b prog %0d want 5 1 3",
                     state, fail, progress);
        end
        step($urandom_range(1, 20));
        pulse_start();
        n_cmp++;
        if (level !== 3'b001 || fail !== 1'b0 || progress !== 4'd0) begin
            n_err++;
            $display("FAIL restart: level %b fail %b prog %0d want 001 0 0",
                     level, fail, progress);
        end
    endtask

    task automatic test_multi_press();
        gen_show(3'b001);
        show_to_input($urandom_range(1, 40));
        btn = 8'b0010_0001;
        step(2);
        btn = 8'd0;
        n_cmp++;
        if (state !== 3'd5 || fail !== 1'b1) begin
            n_err++;
            $display("FAIL multi_press: state %0d fail %b want 5 1", state, fail);
        end
    endtask

    task automatic test_win();
        step($urandom_range(0, 40));
        pulse_start();
        gen_show(3'b001);
        show_to_input($urandom_range(1, 40));
        play_round(8, 3'd1);
        gen_show(3'b010);
        show_to_input($urandom_range(1, 40));
        play_round(12, 3'd1);
        gen_show(3'b100);
        show_to_input($urandom_range(1, 40));
        play_round(16, 3'd6);
        n_cmp++;
        if (win !== 1'b1 || fail !== 1'b0 || level !== 3'b100) begin
            n_err++;
            $display("FAIL win_flags: win %b fail %b level %b want 1 0 100", win, fail, level);
        end
        btn = 8'($urandom_range(1, 255));
        step(4);
        btn = 8'd0;
        n_cmp++;
        if (state !== 3'd6 || win !== 1'b1 || progress !== 4'd0 || level !== 3'b100) begin
            n_err++;
            $display("FAIL win_hold: state %0d win %b prog %0d level %b want 6 1 0 100",
                     state, win, progress, level);
        end
    endtask

`ifdef INPUT_TIMEOUT_EN
    task automatic test_timeout();
        pulse_start();
        gen_show(3'b001);
        show_to_input($urandom_range(1, 40));
        step(99);
        n_cmp++;
        if (state !== 3'd3) begin
            n_err++;
            $display("FAIL timeout_early: state %0d want 3", state);
        end
        step(1);
        n_cmp++;
        if (state !== 3'd5 || fail !== 1'b1) begin
            n_err++;
            $display("FAIL timeout: state %0d fail %b want 5 1", state, fail);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_round_pass();
        test_reset_in_show();
        test_wrong_press();
        test_multi_press();
        test_win();
`ifdef INPUT_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/memory_game_ctrl.md
# memory_game_ctrl

Top-level sequencer for the LED memory game. It generates a pseudo-random 16-entry pattern and drives the pattern-display block through its reset/enable/end handshake. It then checks the player's debounced button presses against the pattern and advances the level (8, 12, 16 entries) or declares fail/win. It sits between the button debouncers and the pattern-display block on the fast system clock.

## Interface
Parameters:
- SEED, 16'hACE1, LFSR reset value; 0 is illegal and is replaced by 16'hACE1.
- TIMEOUT_CYCLES, 50000, per-press input timeout in clk cycles (used only with timeout compiled in).

Ports:
- clk  in  1  fast system clock (≥10 kHz)
- rst  in  1  synchronous, active-high reset
- start  in  1  single-cycle start/restart pulse
- btn  in  8  debounced button levels, bit k = LED k+1
- print_pattern_end  in  1  display block finished showing the pattern
- print_rst_n  out  1  active-low reset to display block
- print_en  out  1  display enable
- level  out  3  one-hot level: 001 = 8 entries, 010 = 12, 100 = 16
- pattern_flat  out  48  entry k at bits [3k+2:3k]; k=0 is shown first
- state  out  3  current FSM state code
- progress  out  4  number of correct presses in the current round
- fail  out  1  high in FAIL
- win  out  1  high in WIN

## Operation
- States: IDLE=0, GEN=1, SHOW=2, INPUT=3, PASS=4, FAIL=5, WIN=6.
- IDLE: start → GEN, level←001.
- GEN: 16 cycles. Each cycle writes entry g←lfsr[2:0] and steps the LFSR. After entry 15 → SHOW.
- LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11+1. It free-runs in every state, so pattern content depends on start timing.
- SHOW: print_rst_n=1, print_en=1. On print_pattern_end=1 → INPUT, with progress←0.
- print_rst_n=0 and print_en=0 in every state except SHOW.
- INPUT: press = rising edge of any btn bit (internal 1-cycle registered edge detect).
  - Exactly one bit rose, and its index equals entry[progress]: progress++.
  - If the new progress equals len → PASS.
  - Wrong index → FAIL.
  - Two or more bits rising in the same cycle → FAIL.
  - Bits already held when INPUT is entered do not count as presses.
- len = 8/12/16 for level 001/010/100.
- PASS: one cycle. If level=100 → WIN; otherwise level←level<<1 and → GEN, which generates a fresh pattern.
- FAIL, WIN: hold. start → GEN with level←001 and progress←0.
- start is ignored in GEN, SHOW, INPUT and PASS.
- Reset values: state=IDLE, level=001, pattern_flat=0, progress=0, fail=0, win=0, print_rst_n=0, print_en=0, LFSR=SEED, edge registers=0.
- Reset mid-operation in any state returns to IDLE on the next edge. The display block is reset through print_rst_n=0 in the same cycle.

## Timing
- start to GEN: 1 cycle. GEN to SHOW: 16 cycles.
- SHOW exit: 1 cycle after print_pattern_end is sampled high.
- Press to progress update: 2 cycles after the btn edge (sync register plus compare).
- The final correct press reaches PASS on the same edge that progress reaches len. PASS to GEN/WIN: 1 cycle.
- print_rst_n rises on the first SHOW cycle and falls on the first cycle after SHOW.
- print_pattern_end is ignored outside SHOW.
- All outputs are registered.

## Configuration
- INPUT_TIMEOUT_EN defined:
  - A counter clears on INPUT entry and on every accepted press.
  - It counts in INPUT; reaching TIMEOUT_CYCLES-1 → FAIL.
  - A press in the same cycle as the timeout wins: it is evaluated normally.
- INPUT_TIMEOUT_EN undefined: no counter exists, and INPUT waits indefinitely.

## Structure
- Shared package holds:
  - the state encoding constants;
  - level one-hot constants;
  - the level→len function (8/12/16);
  - LFSR tap mask and default seed.
- One natural sub-module: game_lfsr16 (clk, rst, seed parameter, 16-bit state out, always steps).
- Pattern storage, edge detect, FSM and timeout stay in the top.

## Test plan
- Reset, then idle 20 cycles → state=0, level=001, print_rst_n=0, print_en=0, fail=win=0, pattern_flat=0.
- start; model print_pattern_end 30 cycles into SHOW; press the 8 correct buttons → progress counts 1..8, PASS, level=010, GEN regenerates.
- At level 001, progress=3, press a wrong button → FAIL with fail=1; next start → GEN with level=001.
- In INPUT, raise btn[0] and btn[5] in the same cycle → FAIL.
- Complete the 8/12/16 rounds correctly → win=1, state=6. A press in WIN changes nothing.
- With INPUT_TIMEOUT_EN and TIMEOUT_CYCLES=100, make no press → FAIL after 100 INPUT cycles. Assert rst in SHOW → IDLE next edge with print_rst_n=0.
